// File: rtl/seq_array_mult.sv
// Multi-cycle WIDTH x WIDTH array multiplier: ROWS_PER_CYCLE partial-product rows per clock into a 2*WIDTH accumulator.
// Optional signed mode is enabled by defining SEQ_ARRAY_MULT_SIGNED_EN, which adds the is_signed port.
module seq_array_mult #(
    parameter int WIDTH          = 16,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
`ifdef SEQ_ARRAY_MULT_SIGNED_EN
    ,
    input  logic                 is_signed
`endif
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_STEP = CW'(ROWS_PER_CYCLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] ROW_MSB  = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_array_mult: WIDTH must be >= 2");
        end
        if ((ROWS_PER_CYCLE < 1) || ((WIDTH % ROWS_PER_CYCLE) != 0)) begin : g_bad_rpc
            $error("seq_array_mult: ROWS_PER_CYCLE must divide WIDTH evenly");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              signed_q;
    logic              accept_s;
    logic [PW-1:0]     a_ext_s;
    logic [PW-1:0]     band_sum_s;
    logic [PW-1:0]     row_pp_s;
    logic [CW-1:0]     row_idx_s;

`ifdef SEQ_ARRAY_MULT_SIGNED_EN
    logic              signed_d;

    // Signedness is captured together with the operands on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            signed_q <= 1'b0;
        end else begin
            signed_q <= signed_d;
        end
    end

    // Hold the latched mode except on an accepted operand pair.
    always_comb begin
        if (accept_s) begin
            signed_d = is_signed;
        end else begin
            signed_d = signed_q;
        end
    end
`else
    assign signed_q = 1'b0;
`endif

    assign accept_s = in_valid && in_ready_q;
    assign a_ext_s  = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};

    // One band of partial-product rows; the first band starts from zero so p only moves in RUN.
    always_comb begin
        band_sum_s = (cnt_q == {CW{1'b0}}) ? {PW{1'b0}} : acc_q;
        row_pp_s   = {PW{1'b0}};
        row_idx_s  = cnt_q;
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
            row_idx_s = cnt_q + CW'(j);
            if (b_q[row_idx_s[IW-1:0]]) begin
                row_pp_s = a_ext_s << row_idx_s;
            end else begin
                row_pp_s = {PW{1'b0}};
            end
            // In signed mode the multiplier MSB carries negative weight.
            if (signed_q && (row_idx_s == ROW_MSB)) begin
                band_sum_s = band_sum_s - row_pp_s;
            end else begin
                band_sum_s = band_sum_s + row_pp_s;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            acc_q       <= {PW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = band_sum_s;
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_d == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the next state and registered, so in_ready never sees out_ready combinationally.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            ST_IDLE: in_ready_d  = 1'b1;
            ST_RUN:  busy_d      = 1'b1;
            ST_DONE: out_valid_d = 1'b1;
            default: in_ready_d  = 1'b0;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = acc_q;

endmodule

// File: tb/tb_seq_array_mult.sv
// Bench for seq_array_mult: WIDTH=16 instances with ROWS_PER_CYCLE=1 and 4 driven in lockstep,
// checked against an arithmetic reference product.
module tb_seq_array_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        is_signed = 1'b0;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        in_ready, out_valid, busy;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] p, p4;
    int          err_cnt = 0;
    int          chk_cnt = 0;

`ifdef SEQ_ARRAY_MULT_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_array_mult #(.WIDTH(16), .ROWS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
`ifdef SEQ_ARRAY_MULT_SIGNED_EN
        , .is_signed(is_signed)
`endif
    );

    seq_array_mult #(.WIDTH(16), .ROWS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready), .p(p4), .busy(busy4)
`ifdef SEQ_ARRAY_MULT_SIGNED_EN
        , .is_signed(is_signed)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_mult(input logic [15:0] x, input logic [15:0] y, input logic sgn);
        longint sx, sy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'(x);
            sy = longint'(y);
        end
        return 32'(sx * sy);
    endfunction

    // One full transaction through both instances; stall cycles in DONE also offer an operand that must be ignored.
    task automatic mult_txn(input logic [15:0] op_a, input logic [15:0] op_b, input logic sgn,
                            input int stall, input logic [31:0] exp_p);
        int k, lat1, lat4, busy_n;
        k = 0;
        while (!in_ready && k < 64) begin
            tick();
            k++;
        end
        chk("ready_before", in_ready, 1'b1);
        a = op_a; b = op_b; is_signed = sgn; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("ready_drop", in_ready, 1'b0);
        lat1 = -1; lat4 = -1; busy_n = 0;
        for (int c = 0; c < 64 && lat1 < 0; c++) begin
            if (c > 0) tick();
            if (out_valid4 && lat4 < 0) lat4 = c;
            if (out_valid && lat1 < 0) lat1 = c;
            if (busy) busy_n++;
        end
        chk("latency_rpc1", lat1, 16);
        chk("latency_rpc4", lat4, 4);
        chk("busy_cycles", busy_n, 16);
        chk("p_rpc1", p, exp_p);
        chk("p_rpc4", p4, exp_p);
        for (int s = 0; s < stall; s++) begin
            if (s == 0) begin
                in_valid = 1'b1; a = ~op_a; b = ~op_b;
            end
            tick();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_ready", in_ready, 1'b0);
            chk("stall_p", p, exp_p);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("take_valid", {out_valid, out_valid4}, 2'b00);
        chk("take_ready", {in_ready, in_ready4}, 2'b11);
        chk("take_busy", busy, 1'b0);
        chk("idle_p_hold", p, exp_p);
    endtask

    initial begin
        int k;
        logic [15:0] ra, rb;
        logic        rs;

        tick();
        tick();
        chk("rst_ready", {in_ready, in_ready4}, 2'b11);
        chk("rst_valid", {out_valid, out_valid4}, 2'b00);
        chk("rst_busy", {busy, busy4}, 2'b00);
        chk("rst_p", {p, p4}, 64'd0);
        rst_n = 1'b1;
        tick();

        mult_txn(16'd3, 16'd5, 1'b0, 0, 32'h0000_000F);
        mult_txn(16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE_0001);
        mult_txn(16'h1234, 16'h0010, 1'b0, 10, 32'h0001_2340);
        mult_txn(16'h0000, 16'hBEEF, 1'b0, 1, 32'h0000_0000);

        // Reset in the middle of RUN discards the product.
        a = 16'h00FF; b = 16'hFFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        chk("mid_run_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_ready", {in_ready, in_ready4}, 2'b11);
        chk("mrst_valid", {out_valid, out_valid4}, 2'b00);
        chk("mrst_busy", {busy, busy4}, 2'b00);
        chk("mrst_p", {p, p4}, 64'd0);
        mult_txn(16'd2, 16'd2, 1'b0, 0, 32'd4);

        // Back-to-back with in_valid held; only the RPC=1 instance is tracked here.
        a = 16'd7; b = 16'd9; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        a = 16'd10; b = 16'd10;
        k = 0;
        while (!out_valid && k < 64) begin tick(); k++; end
        chk("b2b_first", p, 32'd63);
        tick();
        chk("b2b_no_same_cycle", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("b2b_second_accept", in_ready, 1'b0);
        k = 0;
        while (!out_valid && k < 64) begin tick(); k++; end
        chk("b2b_second", p, 32'd100);
        tick();
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

`ifdef SEQ_ARRAY_MULT_SIGNED_EN
        mult_txn(16'hFFFF, 16'hFFFF, 1'b1, 0, 32'h0000_0001);
        mult_txn(16'h8000, 16'h0002, 1'b1, 0, 32'hFFFF_0000);
        mult_txn(16'h8000, 16'h8000, 1'b1, 0, 32'h4000_0000);
        mult_txn(16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE_0001);
`endif

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) ra = 16'd0;
            if (i == 1) rb = 16'd0;
            rs = SGN_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            mult_txn(ra, rb, rs, $urandom_range(0, 3), ref_mult(ra, rb, rs));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
